// File: rtl/dmem_arbiter_ctrl.sv
// Data-memory front end: arbitrates core and debug ports, extracts sub-word loads
// and turns byte/half stores into a two-cycle read-modify-write.
module dmem_arbiter_ctrl #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [1:0]  c_size,
  input  logic        c_uns,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_done,
  output logic        c_err,
  output logic        c_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t      state;
  logic        rr_last;   // 1: debug was granted last
  logic [31:0] rmw_word;
  logic [31:0] rmw_addr;

  logic        misal;
  logic        core_win;
  logic        dbg_win;
  logic        sub_store;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] merged;
  logic        unused_ok;

  assign unused_ok = ^d_addr[1:0];

  assign misal = (c_size == 2'b11) ||
                 (c_size == 2'b01 && c_addr[0]) ||
                 (c_size == 2'b10 && c_addr[1:0] != 2'b00);

  // Core takes a tie when round-robin is off or debug went last.
  assign core_win  = (state == IDLE) && c_req && (!d_req || !RR_EN || rr_last);
  assign dbg_win   = (state == IDLE) && d_req && !core_win;
  assign sub_store = c_we && !misal && (c_size != 2'b10);

  assign lane_b = 8'(mem_rd >> {c_addr[1:0], 3'b000});
  assign lane_h = c_addr[1] ? mem_rd[31:16] : mem_rd[15:0];

  always_comb begin
    merged = mem_rd;
    if (c_size == 2'b00) begin
      case (c_addr[1:0])
        2'd0:    merged[7:0]   = c_wdata[7:0];
        2'd1:    merged[15:8]  = c_wdata[7:0];
        2'd2:    merged[23:16] = c_wdata[7:0];
        default: merged[31:24] = c_wdata[7:0];
      endcase
    end else if (c_addr[1]) begin
      merged[31:16] = c_wdata[15:0];
    end else begin
      merged[15:0] = c_wdata[15:0];
    end
  end

  always_comb begin
    c_rdata = '0;
    c_done  = 1'b0;
    c_err   = 1'b0;
    d_rdata = '0;
    d_done  = 1'b0;
    mem_we  = 1'b0;
    mem_a   = '0;
    mem_wd  = '0;
    if (!rst) begin
      if (state == RMW_WR) begin
        mem_we = 1'b1;
        mem_a  = rmw_addr;
        mem_wd = rmw_word;
        c_done = 1'b1;
      end else if (core_win) begin
        if (misal) begin
          c_done = 1'b1;
          c_err  = 1'b1;
        end else begin
          mem_a = c_addr;
          if (!c_we) begin
            c_done = 1'b1;
            case (c_size)
              2'b00:   c_rdata = c_uns ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
              2'b01:   c_rdata = c_uns ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
              default: c_rdata = mem_rd;
            endcase
          end else if (!sub_store) begin
            mem_we = 1'b1;
            mem_wd = c_wdata;
            c_done = 1'b1;
          end
        end
      end else if (dbg_win) begin
        mem_a   = {d_addr[31:2], 2'b00};
        mem_we  = d_we;
        mem_wd  = d_wdata;
        d_rdata = mem_rd;
        d_done  = 1'b1;
      end
    end
  end

  assign c_stall = c_req && !c_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      rmw_word <= '0;
      rmw_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (core_win) begin
            rr_last <= 1'b0;
            if (sub_store) begin
              rmw_word <= merged;
              rmw_addr <= c_addr;
              state    <= RMW_WR;
            end
          end else if (dbg_win) begin
            rr_last <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// Directed bench: round-robin instance checked throughout, fixed-priority twin for starvation.
module tb_dmem_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, c_uns, d_req, d_we;
  logic [1:0]  c_size;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;

  logic [31:0] c_rdata, d_rdata, mem_a, mem_wd, mem_rd;
  logic        c_done, c_err, c_stall, d_done, mem_we;

  logic [31:0] unused_c_rdata0, unused_d_rdata0, mem_a0, mem_wd0, mem_rd0;
  logic        c_done0, unused_c_err0, unused_c_stall0, d_done0, mem_we0;
  logic        unused_bits;

  logic [31:0] mem  [1024];
  logic [31:0] mem0 [1024];
  logic        bd_we;
  logic [9:0]  bd_idx;
  logic [31:0] bd_dat;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter_ctrl #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_uns(c_uns),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_done(c_done), .c_err(c_err),
    .c_stall(c_stall), .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  dmem_arbiter_ctrl #(.RR_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_uns(c_uns),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(unused_c_rdata0), .c_done(c_done0),
    .c_err(unused_c_err0), .c_stall(unused_c_stall0), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(unused_d_rdata0), .d_done(d_done0),
    .mem_we(mem_we0), .mem_a(mem_a0), .mem_wd(mem_wd0), .mem_rd(mem_rd0)
  );

  assign mem_rd      = mem[mem_a[11:2]];
  assign mem_rd0     = mem0[mem_a0[11:2]];
  assign unused_bits = ^{mem_a[31:12], mem_a[1:0], mem_a0[31:12], mem_a0[1:0]};

  always @(posedge clk) begin
    if (mem_we)      mem[mem_a[11:2]] <= mem_wd;
    else if (bd_we)  mem[bd_idx]      <= bd_dat;
    if (mem_we0)     mem0[mem_a0[11:2]] <= mem_wd0;
    else if (bd_we)  mem0[bd_idx]       <= bd_dat;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    bd_we  = 1'b1;
    bd_idx = idx;
    bd_dat = val;
    tick();
    bd_we  = 1'b0;
  endtask

  task automatic core(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    c_req   = 1'b1;
    c_we    = we;
    c_size  = size;
    c_uns   = uns;
    c_addr  = addr;
    c_wdata = wdata;
  endtask

  initial begin
    rst = 1'b1; c_req = 0; c_we = 0; c_size = 0; c_uns = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; bd_we = 0; bd_idx = 0; bd_dat = 0;
    #1;
    preload(10'd4, 32'h0000000A);
    preload(10'd1, 32'h80FF7F01);
    preload(10'd2, 32'h11223344);

    // Requests during reset must be ignored
    core(1'b1, 2'b10, 1'b0, 32'd16, 32'hDEADBEEF);
    d_req = 1'b1;
    #4;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_c_done", 32'(c_done), 32'd0);
    chk("rst_d_done", 32'(d_done), 32'd0);
    chk("rst_c_err",  32'(c_err),  32'd0);
    tick();
    rst = 1'b0; c_req = 1'b0; d_req = 1'b0;
    #4;
    chk("idle_mem_we", 32'(mem_we), 32'd0);
    chk("idle_mem_a",  mem_a, 32'd0);
    chk("rst_no_write", mem[4], 32'h0000000A);
    tick();

    core(1'b0, 2'b10, 1'b0, 32'd16, 32'd0); #4;
    chk("lw16_done",  32'(c_done),  32'd1);
    chk("lw16_data",  c_rdata,      32'h0000000A);
    chk("lw16_stall", 32'(c_stall), 32'd0);
    tick();
    core(1'b0, 2'b00, 1'b0, 32'd5, 32'd0); #4; chk("lb5",  c_rdata, 32'h0000007F); tick();
    core(1'b0, 2'b00, 1'b0, 32'd7, 32'd0); #4; chk("lb7",  c_rdata, 32'hFFFFFF80); tick();
    core(1'b0, 2'b00, 1'b1, 32'd7, 32'd0); #4; chk("lbu7", c_rdata, 32'h00000080); tick();
    core(1'b0, 2'b01, 1'b0, 32'd6, 32'd0); #4; chk("lh6",  c_rdata, 32'hFFFF80FF); tick();
    core(1'b0, 2'b01, 1'b1, 32'd6, 32'd0); #4; chk("lhu6", c_rdata, 32'h000080FF); tick();

    core(1'b1, 2'b00, 1'b0, 32'd9, 32'h000000AB); #4;
    chk("sb_c1_stall",  32'(c_stall), 32'd1);
    chk("sb_c1_mem_we", 32'(mem_we),  32'd0);
    tick(); #4;
    chk("sb_c2_mem_we", 32'(mem_we), 32'd1);
    chk("sb_c2_mem_wd", mem_wd,      32'h1122AB44);
    chk("sb_c2_mem_a",  mem_a,       32'd9);
    chk("sb_c2_done",   32'(c_done), 32'd1);
    tick();
    core(1'b0, 2'b10, 1'b0, 32'd8, 32'd0); #4; chk("sb_readback", c_rdata, 32'h1122AB44); tick();
    core(1'b1, 2'b01, 1'b0, 32'd10, 32'h0000BEEF); #4;
    chk("sh_c1_done", 32'(c_done), 32'd0);
    tick(); #4;
    chk("sh_c2_mem_wd", mem_wd, 32'hBEEFAB44);
    tick();
    chk("sh_mem2", mem[2], 32'hBEEFAB44);

    // Lone debug write leaves rr_last = debug
    c_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000000F; d_wdata = 32'hCAFEF00D; #4;
    chk("dbg_wr_done",   32'(d_done), 32'd1);
    chk("dbg_wr_mem_a",  mem_a,       32'h0000000C);
    chk("dbg_wr_mem_we", 32'(mem_we), 32'd1);
    tick();
    chk("dbg_wr_mem3", mem[3], 32'hCAFEF00D);

    core(1'b0, 2'b10, 1'b0, 32'd16, 32'd0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd12;
    for (int i = 0; i < 4; i++) begin
      #4;
      if (i % 2 == 0) begin
        chk("rr_core_done", 32'(c_done), 32'd1);
        chk("rr_core_data", c_rdata,     32'h0000000A);
        chk("rr_core_dbg0", 32'(d_done), 32'd0);
        chk("rr_core_drd0", d_rdata,     32'd0);
      end else begin
        chk("rr_dbg_done",  32'(d_done),  32'd1);
        chk("rr_dbg_data",  d_rdata,      32'hCAFEF00D);
        chk("rr_dbg_stall", 32'(c_stall), 32'd1);
      end
      chk("fixed_dbg_starved", 32'(d_done0), 32'd0);
      chk("fixed_core_done",   32'(c_done0), 32'd1);
      tick();
    end

    // Debug must wait out the whole read-modify-write
    core(1'b1, 2'b00, 1'b0, 32'd9, 32'h00000055);
    d_addr = 32'd8; #4;
    chk("lock_c1_cdone", 32'(c_done), 32'd0);
    chk("lock_c1_ddone", 32'(d_done), 32'd0);
    tick(); #4;
    chk("lock_c2_mem_wd", mem_wd,      32'hBEEF5544);
    chk("lock_c2_ddone",  32'(d_done), 32'd0);
    chk("lock_c2_cdone",  32'(c_done), 32'd1);
    tick();
    c_req = 1'b0; #4;
    chk("lock_c3_ddone", 32'(d_done), 32'd1);
    chk("lock_c3_data",  d_rdata,     32'hBEEF5544);
    tick();
    d_req = 1'b0;

    core(1'b0, 2'b10, 1'b0, 32'd18, 32'd0); #4;
    chk("mis_lw_done", 32'(c_done), 32'd1);
    chk("mis_lw_err",  32'(c_err),  32'd1);
    chk("mis_lw_data", c_rdata,     32'd0);
    chk("mis_lw_we",   32'(mem_we), 32'd0);
    tick();
    core(1'b1, 2'b01, 1'b0, 32'd13, 32'h0000FFFF); #4;
    chk("mis_sh_done", 32'(c_done), 32'd1);
    chk("mis_sh_err",  32'(c_err),  32'd1);
    chk("mis_sh_we",   32'(mem_we), 32'd0);
    tick();
    core(1'b1, 2'b11, 1'b0, 32'd8, 32'h12345678); #4;
    chk("mis_sz_done", 32'(c_done), 32'd1);
    chk("mis_sz_err",  32'(c_err),  32'd1);
    chk("mis_sz_we",   32'(mem_we), 32'd0);
    tick();
    c_req = 1'b0;
    chk("mis_mem2", mem[2], 32'hBEEF5544);
    chk("mis_mem3", mem[3], 32'hCAFEF00D);

    // Reset landing in RMW_WR aborts the write
    core(1'b1, 2'b00, 1'b0, 32'd16, 32'h00000077); #4;
    chk("abort_c1_done", 32'(c_done), 32'd0);
    tick();
    #1 rst = 1'b1;
    #2;
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_cdone",  32'(c_done), 32'd0);
    chk("abort_ddone",  32'(d_done), 32'd0);
    c_req = 1'b0;
    tick();
    chk("abort_mem4", mem[4], 32'h0000000A);
    rst = 1'b0; #4;
    chk("abort_idle_we", 32'(mem_we), 32'd0);
    chk("abort_idle_a",  mem_a,       32'd0);
    tick();
    core(1'b0, 2'b10, 1'b0, 32'd16, 32'd0); #4;
    chk("reissue_done", 32'(c_done), 32'd1);
    chk("reissue_data", c_rdata,     32'h0000000A);
    tick();
    c_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
